// File: rtl/as_edge_detect_multi_pkg.sv
// Shared definitions for the multi-channel async edge detector.
// Optional sticky event flags are built when AS_EDGE_STICKY_EN is defined.
package as_edge_detect_multi_pkg;

  // Per-channel edge select encoding.
  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // Ceiling log2 with a floor of one bit, used to size the filter counter.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned n = value - 1; n > 0; n = n >> 1) begin
      res = res + 1;
    end
    if (res == 0) res = 1;
    return res;
  endfunction

endpackage

// File: rtl/as_edge_detect_multi_if.sv
// Channel bus of the multi-channel edge detector.
interface as_edge_detect_multi_if #(
  parameter int unsigned CHANNELS = 4
);

  logic [CHANNELS-1:0]   din;
  logic [2*CHANNELS-1:0] mode;
  logic [CHANNELS-1:0]   evt_clr;
  logic [CHANNELS-1:0]   dout;
  logic [CHANNELS-1:0]   level;
  logic [CHANNELS-1:0]   evt;

  modport master (
    output din, mode, evt_clr,
    input  dout, level, evt
  );

  modport slave (
    input  din, mode, evt_clr,
    output dout, level, evt
  );

endinterface

// File: rtl/as_edge_chan.sv
// One channel: synchroniser, stability filter, edge qualifier, optional sticky flag.
// Sticky flag is built only when AS_EDGE_STICKY_EN is defined.
module as_edge_chan
  import as_edge_detect_multi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_CNT  = 1,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       din,
  input  logic [1:0] mode,
  input  logic       evt_clr,
  output logic       dout,
  output logic       level,
  output logic       evt
);

  localparam int unsigned CW = clog2(FILTER_CNT + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   level_d;
  logic                   dout_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchroniser chain, filter state and pulse register, all on the falling edge.
  always_ff @(negedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q  <= '0;
      level  <= RESET_LEVEL;
      dout   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      cnt_q  <= cnt_d;
      level  <= level_d;
      dout   <= dout_d;
    end
  end

  // Filter: accept a new level after FILTER_CNT consecutive differing samples.
  always_comb begin
    cnt_d   = '0;
    level_d = level;
    dout_d  = 1'b0;
    if (synced != level) begin
      if (cnt_q == CW'(FILTER_CNT - 1)) begin
        level_d = synced;
        dout_d  = synced ? (mode == EDGE_RISE || mode == EDGE_BOTH)
                         : (mode == EDGE_FALL || mode == EDGE_BOTH);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

`ifdef AS_EDGE_STICKY_EN
  // Sticky flag: set by a pulse, held until cleared; a set beats a same-cycle clear.
  always_ff @(negedge clk or negedge rst_b) begin
    if (!rst_b) begin
      evt <= 1'b0;
    end else begin
      evt <= dout_d | (evt & ~evt_clr);
    end
  end
`else
  logic unused_evt_clr;
  assign unused_evt_clr = evt_clr;
  assign evt = 1'b0;
`endif

endmodule

// File: rtl/as_edge_detect_multi.sv
// Multi-channel async edge detector: one as_edge_chan per input line.
// Optional sticky event flags are enabled by defining AS_EDGE_STICKY_EN.
module as_edge_detect_multi
  import as_edge_detect_multi_pkg::*;
#(
  parameter int unsigned         CHANNELS    = 4,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter int unsigned         FILTER_CNT  = 1,
  parameter logic [CHANNELS-1:0] RESET_LEVEL = '0
) (
  input logic                  clk,
  input logic                  rst_b,
  as_edge_detect_multi_if.slave bus
);

  logic [CHANNELS-1:0] dout_w;
  logic [CHANNELS-1:0] level_w;
  logic [CHANNELS-1:0] evt_w;

  // Independent per-channel instances with sliced ports.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    as_edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_CNT  (FILTER_CNT),
      .RESET_LEVEL (RESET_LEVEL[i])
    ) u_chan (
      .clk     (clk),
      .rst_b   (rst_b),
      .din     (bus.din[i]),
      .mode    (bus.mode[2*i +: 2]),
      .evt_clr (bus.evt_clr[i]),
      .dout    (dout_w[i]),
      .level   (level_w[i]),
      .evt     (evt_w[i])
    );
  end

  assign bus.dout  = dout_w;
  assign bus.level = level_w;
  assign bus.evt   = evt_w;

endmodule

// File: tb/tb_as_edge_detect_multi.sv
// Directed bench for as_edge_detect_multi: F=1, F=3 and F=4 instances.
module tb_as_edge_detect_multi;

  logic clk = 1'b0;
  logic rst_b;
  int   n_checks = 0;
  int   n_err = 0;
  logic [3:0] a_lvl;

  always #5 clk = ~clk;

  as_edge_detect_multi_if #(.CHANNELS(4)) ifa ();
  as_edge_detect_multi_if #(.CHANNELS(4)) ifb ();
  as_edge_detect_multi_if #(.CHANNELS(4)) ifc ();

  as_edge_detect_multi #(.CHANNELS(4), .SYNC_STAGES(2), .FILTER_CNT(1)) dut_a (
    .clk(clk), .rst_b(rst_b), .bus(ifa));
  as_edge_detect_multi #(.CHANNELS(4), .SYNC_STAGES(2), .FILTER_CNT(3)) dut_b (
    .clk(clk), .rst_b(rst_b), .bus(ifb));
  as_edge_detect_multi #(.CHANNELS(4), .SYNC_STAGES(2), .FILTER_CNT(4)) dut_c (
    .clk(clk), .rst_b(rst_b), .bus(ifc));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive ifa.din, then follow four sampling points; pulse expected at the third.
  task automatic run_a(input string tag, input logic [3:0] din_v, input logic [3:0] pulse);
    ifa.din = din_v;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      chk({tag, "_dout"}, 8'(ifa.dout), (i == 3) ? 8'(pulse) : 8'h00);
      chk({tag, "_lvl"}, 8'(ifa.level), (i >= 3) ? 8'(din_v) : 8'(a_lvl));
    end
    a_lvl = din_v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b0;
    ifa.din = '0; ifa.mode = 8'h55; ifa.evt_clr = '0;
    ifb.din = '0; ifb.mode = 8'hFF; ifb.evt_clr = '0;
    ifc.din = '0; ifc.mode = 8'hFF; ifc.evt_clr = '0;
    a_lvl = 4'h0;

    // Reset state
    repeat (3) @(posedge clk);
    chk("rst_a_dout", 8'(ifa.dout), 8'h00);
    chk("rst_a_lvl", 8'(ifa.level), 8'h00);
    chk("rst_a_evt", 8'(ifa.evt), 8'h00);
    chk("rst_b_lvl", 8'(ifb.level), 8'h00);
    chk("rst_c_lvl", 8'(ifc.level), 8'h00);
    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      chk("post_rst_dout", 8'(ifa.dout), 8'h00);
      chk("post_rst_lvl", 8'(ifa.level), 8'h00);
    end

    // Rise-only, fall-only, off and late-enable on the F=1 instance
    run_a("rise0", 4'b0001, 4'b0001);
    run_a("fall0_risemode", 4'b0000, 4'b0000);
    ifa.mode = 8'hAA;
    run_a("rise0_fallmode", 4'b0001, 4'b0000);
    run_a("fall0_fallmode", 4'b0000, 4'b0001);
    ifa.mode = 8'h00;
    run_a("mode_off", 4'b0010, 4'b0000);
    ifa.mode = 8'hFF;
    run_a("enable_late", 4'b0010, 4'b0000);

    // Both edges, staggered and simultaneous
    run_a("both_ch0_ch3", 4'b1011, 4'b1001);
    run_a("both_ch2", 4'b1111, 4'b0100);
    run_a("both_ch1", 4'b1101, 4'b0010);
    run_a("both_fall3", 4'b0000, 4'b1101);

    // Sticky flags: clear everything first
    ifa.evt_clr = 4'hF;
    @(posedge clk);
    ifa.evt_clr = 4'h0;
    chk("evt_cleared", 8'(ifa.evt), 8'h00);
`ifdef AS_EDGE_STICKY_EN
    ifa.din = 4'b0100;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      chk("evt_set", 8'(ifa.evt), (i >= 3) ? 8'h04 : 8'h00);
    end
    ifa.din = 4'b0000;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      chk("evt_set_vs_clr", 8'(ifa.evt), 8'h04);
      if (i == 3) chk("evt_set_vs_clr_dout", 8'(ifa.dout), 8'h04);
      ifa.evt_clr = (i == 2) ? 4'b0100 : 4'b0000;
    end
    ifa.evt_clr = 4'b0100;
    @(posedge clk);
    ifa.evt_clr = 4'b0000;
    chk("evt_clr_alone", 8'(ifa.evt), 8'h00);
    a_lvl = 4'b0000;
`else
    chk("evt_tied_b", 8'(ifb.evt), 8'h00);
`endif

    // Glitch filter on the F=3 instance: two samples high is rejected
    ifb.din = 4'b0010;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      if (i == 2) ifb.din = 4'b0000;
      chk("glitch_dout", 8'(ifb.dout), 8'h00);
      chk("glitch_lvl", 8'(ifb.level), 8'h00);
    end
    ifb.din = 4'b0010;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      chk("filt_dout", 8'(ifb.dout), (i == 5) ? 8'h02 : 8'h00);
      chk("filt_lvl", 8'(ifb.level), (i >= 5) ? 8'h02 : 8'h00);
    end

    // Async reset while the F=4 counter sits at 2
    ifc.din = 4'b0100;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      chk("c_pre_rst_dout", 8'(ifc.dout), 8'h00);
      chk("c_pre_rst_lvl", 8'(ifc.level), 8'h00);
    end
    #2;
    rst_b = 1'b0;
    #1;
    chk("async_b_lvl", 8'(ifb.level), 8'h00);
    chk("async_c_lvl", 8'(ifc.level), 8'h00);
    chk("async_c_dout", 8'(ifc.dout), 8'h00);
    ifb.din = 4'b0000;
    ifc.din = 4'b0000;
    #1;
    rst_b = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      chk("c_post_rst_dout", 8'(ifc.dout), 8'h00);
      chk("c_post_rst_lvl", 8'(ifc.level), 8'h00);
      chk("b_post_rst_dout", 8'(ifb.dout), 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
